trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer_pkg.sv | 41 ++++
 rtl/trace_buffer_column_ram.sv | 45 ++++
 rtl/trace_buffer.sv | 172 +++++++++++++++++
 tb/tb_trace_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_buffer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : trace_buffer_pkg
//  Description : Shared raybox parameters for the trace buffer. Holds the
//                screen geometry defaults, the fixed-point comparison width,
//                the 9-bit column entry layout {side,height} and the height
//                clamp helper.
//  Revision    : 1.0  initial release
// ============================================================================
package trace_buffer_pkg;

    // Screen geometry defaults
    localparam int c_COLS_DEFAULT = 640;   // columns stored per frame
    localparam int c_HMAX_DEFAULT = 240;   // wall half-height clamp / centre row

    // Field widths
    localparam int c_COL_W    = 10;        // column / hpos / vpos width
    localparam int c_HEIGHT_W = 8;         // wall half-height width
    localparam int c_ENTRY_W  = 9;         // stored entry width {side,height}
    localparam int c_CMP_W    = 11;        // range compare width, HMAX+h cannot wrap

    // One stored column: wall side bit above the half-height
    typedef struct packed {
        logic                  side;
        logic [c_HEIGHT_W-1:0] height;
    } entry_t;

    // min(h, hmax); a clamp above the height range leaves h untouched
    function automatic logic [c_HEIGHT_W-1:0] clampHeight(
        input logic [c_HEIGHT_W-1:0] h,
        input int                    hmax
    );
        if (int'(h) > hmax) begin
            return c_HEIGHT_W'(hmax);
        end
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_buffer_column_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : column_ram
//  Description : Double-banked column store, 1 write port / 1 read port,
//                synchronous read. 2*COLS entries of {side,height}; the bank
//                bit is the most significant address component.
//  Ports       : clk        - clock
//                i_wrEn     - write enable
//                i_wrBank   - bank written
//                i_wrCol    - column written (caller guarantees < COLS)
//                i_wrData   - entry written
//                i_rdBank   - bank read
//                i_rdCol    - column read (caller guarantees < COLS)
//                o_rdData   - registered read data, valid one cycle later
//  Revision    : 1.0  initial release
// ============================================================================
module column_ram
    import trace_buffer_pkg::*;
#(
    parameter int COLS   = c_COLS_DEFAULT,
    parameter int ADDR_W = $clog2(c_COLS_DEFAULT)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic              i_wrBank,
    input  logic [ADDR_W-1:0] i_wrCol,
    input  entry_t            i_wrData,
    input  logic              i_rdBank,
    input  logic [ADDR_W-1:0] i_rdCol,
    output entry_t            o_rdData
);

    // Bank-major storage: r_mem[bank][column]. Contents are never reset.
    entry_t r_mem [2][COLS];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrBank][i_wrCol] <= i_wrData;
        end
        o_rdData <= r_mem[i_rdBank][i_rdCol];
    end

endmodule
`default_nettype wire

// File: rtl/trace_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : trace_buffer
//  Description : Double-buffered per-column wall store between the ray tracer
//                and the video output. The tracer fills the back bank; a swap
//                request promotes it to front once it holds new data. The
//                video side reads the front bank through a 2-stage pipeline
//                and classifies each pixel as wall / ceiling / floor.
//  Ports       : clk        - clock, all state on rising edge
//                reset      - asynchronous active-high reset
//                store      - write strobe, one column per cycle
//                column     - write column index
//                side       - write wall side bit
//                height     - write wall half-height (0 = no wall)
//                swap_req   - end-of-frame pulse from the tracer
//                hpos/vpos  - current video pixel position
//                visible    - pixel inside active display
//                o_valid    - visible delayed by 2 cycles
//                o_wall     - pixel lies on a wall
//                o_side     - side bit of that wall
//                o_ceiling  - non-wall pixel above the centre row
//                o_floor    - non-wall pixel at or below the centre row
//                o_front    - bank currently displayed
//  Revision    : 1.0  initial release
// ============================================================================
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int COLS = c_COLS_DEFAULT,
    parameter int HMAX = c_HMAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  store,
    input  logic [c_COL_W-1:0]    column,
    input  logic                  side,
    input  logic [c_HEIGHT_W-1:0] height,
    input  logic                  swap_req,
    input  logic [c_COL_W-1:0]    hpos,
    input  logic [c_COL_W-1:0]    vpos,
    input  logic                  visible,
    output logic                  o_valid,
    output logic                  o_wall,
    output logic                  o_side,
    output logic                  o_ceiling,
    output logic                  o_floor,
    output logic                  o_front
);

    localparam int                 c_ADDR_W = $clog2(COLS);
    localparam logic [c_CMP_W-1:0] c_COLS11 = c_CMP_W'(COLS);
    localparam logic [c_CMP_W-1:0] c_HMAX11 = c_CMP_W'(HMAX);

    // ------------------------------------------------------------------
    // Bank control
    // ------------------------------------------------------------------
    logic r_front;
    logic r_backDirty;
    logic r_frontValid;

    logic w_accept;
    logic w_doSwap;

    assign w_accept = store && ({1'b0, column} < c_COLS11);
    // A write landing on the swap edge still counts as new back-bank data
    assign w_doSwap = swap_req && (r_backDirty || w_accept);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_front      <= 1'b0;
            r_backDirty  <= 1'b0;
            r_frontValid <= 1'b0;
        end else if (w_doSwap) begin
            r_front      <= ~r_front;
            r_frontValid <= 1'b1;
            r_backDirty  <= 1'b0;
        end else if (w_accept) begin
            r_backDirty  <= 1'b1;
        end
    end

    assign o_front = r_front;

    // ------------------------------------------------------------------
    // Column store
    // ------------------------------------------------------------------
    entry_t              w_wrData;
    entry_t              w_rdEntry;
    logic                w_hposOk;
    logic [c_ADDR_W-1:0] w_rdCol;

    assign w_wrData = '{side: side, height: clampHeight(height, HMAX)};
    assign w_hposOk = ({1'b0, hpos} < c_COLS11);
    // Off-screen reads are parked on column 0 and masked in stage 2
    assign w_rdCol  = w_hposOk ? hpos[c_ADDR_W-1:0] : '0;

    column_ram #(
        .COLS   (COLS),
        .ADDR_W (c_ADDR_W)
    ) u_columnRam (
        .clk      (clk),
        .i_wrEn   (w_accept),
        .i_wrBank (~r_front),
        .i_wrCol  (column[c_ADDR_W-1:0]),
        .i_wrData (w_wrData),
        .i_rdBank (r_front),
        .i_rdCol  (w_rdCol),
        .o_rdData (w_rdEntry)
    );

    // ------------------------------------------------------------------
    // Stage 1: travels alongside the synchronous RAM read. front_valid is
    // captured with the read so a swap edge affects the same pixels as
    // the bank switch does.
    // ------------------------------------------------------------------
    logic [c_COL_W-1:0] r_s1Vpos;
    logic               r_s1Visible;
    logic               r_s1HposOk;
    logic               r_s1FrontValid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1Vpos       <= '0;
            r_s1Visible    <= 1'b0;
            r_s1HposOk     <= 1'b0;
            r_s1FrontValid <= 1'b0;
        end else begin
            r_s1Vpos       <= vpos;
            r_s1Visible    <= visible;
            r_s1HposOk     <= w_hposOk;
            r_s1FrontValid <= r_frontValid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: wall span is [HMAX-h, HMAX+h). h <= HMAX after the write
    // clamp, so the lower bound never underflows.
    // ------------------------------------------------------------------
    logic [c_CMP_W-1:0] w_h11;
    logic [c_CMP_W-1:0] w_vpos11;
    logic [c_CMP_W-1:0] w_wallLo;
    logic [c_CMP_W-1:0] w_wallHi;
    logic               w_wall;
    logic               w_above;

    assign w_h11    = (r_s1HposOk && r_s1FrontValid) ?
                      {{(c_CMP_W-c_HEIGHT_W){1'b0}}, w_rdEntry.height} : '0;
    assign w_vpos11 = {{(c_CMP_W-c_COL_W){1'b0}}, r_s1Vpos};
    assign w_wallLo = c_HMAX11 - w_h11;
    assign w_wallHi = c_HMAX11 + w_h11;
    assign w_wall   = (w_h11 != '0) && (w_vpos11 >= w_wallLo) && (w_vpos11 < w_wallHi);
    assign w_above  = (w_vpos11 < c_HMAX11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_wall    <= 1'b0;
            o_side    <= 1'b0;
            o_ceiling <= 1'b0;
            o_floor   <= 1'b0;
        end else begin
            o_valid   <= r_s1Visible;
            o_wall    <= r_s1Visible && w_wall;
            o_side    <= r_s1Visible && w_wall && w_rdEntry.side;
            o_ceiling <= r_s1Visible && !w_wall && w_above;
            o_floor   <= r_s1Visible && !w_wall && !w_above;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_trace_buffer
//  Description : Self-checking bench for trace_buffer. Fixed-expectation
//                vector tables per phase, hand-written swap/reset sequences
//                and a streamed line checked against a behavioural bank
//                model through an expected-output scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trace_buffer;

    localparam int c_COLS = 640;
    localparam int c_HMAX = 240;

    logic       clk = 1'b0;
    logic       reset;
    logic       store;
    logic [9:0] column;
    logic       side;
    logic [7:0] height;
    logic       swap_req;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       visible;
    logic       o_valid, o_wall, o_side, o_ceiling, o_floor, o_front;

    trace_buffer #(
        .COLS (c_COLS),
        .HMAX (c_HMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .store     (store),
        .column    (column),
        .side      (side),
        .height    (height),
        .swap_req  (swap_req),
        .hpos      (hpos),
        .vpos      (vpos),
        .visible   (visible),
        .o_valid   (o_valid),
        .o_wall    (o_wall),
        .o_side    (o_side),
        .o_ceiling (o_ceiling),
        .o_floor   (o_floor),
        .o_front   (o_front)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // expected bits: {valid, wall, side, ceiling, floor}
    typedef struct {
        int         due;
        logic [4:0] exp;
        string      nm;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int         phase;
        int         hp;
        int         vp;
        bit         vis;
        logic [4:0] exp;
        string      nm;
    } vec_t;
    vec_t vecs[$];

    // Behavioural model of the banks and swap state
    int mH[2][c_COLS];
    bit mS[2][c_COLS];
    bit mFront, mDirty, mFv;

    task automatic sbDrain();
        logic [4:0] act;
        act = {o_valid, o_wall, o_side, o_ceiling, o_floor};
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            checks++;
            if (sbq[0].due < cyc) begin
                failures++;
                $display("FAIL %s: output not observed on cycle %0d (now %0d)", sbq[0].nm, sbq[0].due, cyc);
            end else if (act !== sbq[0].exp) begin
                failures++;
                $display("FAIL %s: valid/wall/side/ceil/floor got %b required %b", sbq[0].nm, act, sbq[0].exp);
            end
            void'(sbq.pop_front());
        end
    endtask

    // Compare at the falling edge, then advance to just after the rising edge
    task automatic tick();
        @(negedge clk);
        sbDrain();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] modelExp(input int hp, input int vp, input bit vis);
        int h;
        bit s, wall;
        h = 0;
        s = 1'b0;
        if (mFv && hp < c_COLS) begin
            h = mH[mFront][hp];
            s = mS[mFront][hp];
        end
        wall = (h != 0) && (vp >= c_HMAX - h) && (vp < c_HMAX + h);
        return {vis, vis && wall, vis && wall && s, vis && !wall && (vp < c_HMAX), vis && !wall && (vp >= c_HMAX)};
    endfunction

    // One clock of combined write / swap / pixel stimulus; the model is
    // updated for the edge after the pixel's expectation is taken.
    task automatic cyc1(input bit st, input int col, input bit sd, input int ht, input bit sw,
                        input bit vis, input int hp, input int vp, input bit chkPix, input string nm);
        int wb;
        store    = st;
        column   = 10'(col);
        side     = sd;
        height   = 8'(ht);
        swap_req = sw;
        visible  = vis;
        hpos     = 10'(hp);
        vpos     = 10'(vp);
        if (chkPix) sbq.push_back('{due: cyc + 2, exp: modelExp(hp, vp, vis), nm: nm});
        tick();
        wb = mFront ? 0 : 1;
        if (st && col < c_COLS) begin
            mH[wb][col] = (ht > c_HMAX) ? c_HMAX : ht;
            mS[wb][col] = sd;
            mDirty = 1'b1;
        end
        if (sw && mDirty) begin
            mFront = ~mFront;
            mFv    = 1'b1;
            mDirty = 1'b0;
        end
        store    = 1'b0;
        swap_req = 1'b0;
        visible  = 1'b0;
    endtask

    task automatic runPhase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                visible = vecs[i].vis;
                hpos    = 10'(vecs[i].hp);
                vpos    = 10'(vecs[i].vp);
                sbq.push_back('{due: cyc + 2, exp: vecs[i].exp, nm: vecs[i].nm});
                tick();
            end
        end
        visible = 1'b0;
        repeat (3) tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // phase, hpos, vpos, visible, {valid,wall,side,ceil,floor}
        vecs.push_back('{0,   0, 100, 1'b1, 5'b10010, "no-swap ceiling"});
        vecs.push_back('{0,   5, 300, 1'b1, 5'b10001, "no-swap floor"});
        vecs.push_back('{0,   5, 100, 1'b0, 5'b00000, "invisible"});
        vecs.push_back('{1,   5, 200, 1'b1, 5'b11100, "h40 top edge"});
        vecs.push_back('{1,   5, 199, 1'b1, 5'b10010, "h40 above"});
        vecs.push_back('{1,   5, 280, 1'b1, 5'b10001, "h40 below"});
        vecs.push_back('{1,   5, 279, 1'b1, 5'b11100, "h40 bottom edge"});
        vecs.push_back('{1,   5, 240, 1'b1, 5'b11100, "h40 centre"});
        vecs.push_back('{1, 700, 250, 1'b1, 5'b10001, "hpos off-screen"});
        vecs.push_back('{1,   5, 200, 1'b0, 5'b00000, "wall gated by visible"});
        vecs.push_back('{2,   0,   0, 1'b1, 5'b11000, "clamped top row"});
        vecs.push_back('{2,   0, 479, 1'b1, 5'b11000, "clamped last wall row"});
        vecs.push_back('{2,   0, 480, 1'b1, 5'b10001, "clamped below span"});
        vecs.push_back('{3,   0,  10, 1'b1, 5'b11000, "front intact after col700"});
        vecs.push_back('{4,   9, 230, 1'b1, 5'b11000, "col9 top edge"});
        vecs.push_back('{4,   9, 229, 1'b1, 5'b10010, "col9 above"});
        vecs.push_back('{4,   9, 249, 1'b1, 5'b11000, "col9 bottom edge"});
        vecs.push_back('{4,   9, 250, 1'b1, 5'b10001, "col9 below"});
        vecs.push_back('{4,   5, 200, 1'b1, 5'b11100, "col5 kept in bank"});
        vecs.push_back('{5,   3, 240, 1'b1, 5'b10001, "post-reset floor"});
        vecs.push_back('{5,   3,  10, 1'b1, 5'b10010, "post-reset ceiling"});

        reset = 1'b1; store = 1'b0; column = '0; side = 1'b0; height = '0;
        swap_req = 1'b0; hpos = '0; vpos = '0; visible = 1'b0;
        mFront = 1'b0; mDirty = 1'b0; mFv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", int'({o_valid, o_wall, o_side, o_ceiling, o_floor}), 0);
        chk("reset o_front", int'(o_front), 0);
        reset = 1'b0;
        idle(2);

        // Before any swap only ceiling/floor are shown
        runPhase(0);

        // Column 5, h40, side 1, then swap
        cyc1(1'b1, 5, 1'b1, 40, 1'b0, 1'b0, 0, 0, 1'b0, "");
        cyc1(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, "");
        chk("first swap o_front", int'(o_front), 1);
        runPhase(1);

        // Height 255 at column 0 is clamped to 240
        cyc1(1'b1, 0, 1'b0, 255, 1'b0, 1'b0, 0, 0, 1'b0, "");
        cyc1(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, "");
        chk("second swap o_front", int'(o_front), 0);
        runPhase(2);

        // Out-of-range write is dropped and does not arm a swap
        cyc1(1'b1, 700, 1'b1, 100, 1'b0, 1'b0, 0, 0, 1'b0, "");
        cyc1(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, "");
        chk("col700 swap ignored", int'(o_front), 0);
        runPhase(3);

        // Write and swap on the same edge
        cyc1(1'b1, 9, 1'b0, 10, 1'b1, 1'b0, 0, 0, 1'b0, "");
        chk("store+swap o_front", int'(o_front), 1);
        runPhase(4);

        // Fill both banks, then stream a line with a swap at column 320
        for (int c = 0; c < c_COLS; c++) cyc1(1'b1, c, c[0], (c * 7) % 256, 1'b0, 1'b0, 0, 0, 1'b0, "");
        cyc1(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, "");
        chk("fill swap o_front", int'(o_front), 0);
        for (int c = 0; c < c_COLS; c++) cyc1(1'b1, c, ~c[0], (c * 13 + 5) % 256, 1'b0, 1'b0, 0, 0, 1'b0, "");
        for (int c = 0; c < c_COLS; c++)
            cyc1(1'b0, 0, 1'b0, 0, (c == 320), (c % 17) != 0, c, (c * 3) % 480, 1'b1, "stream pixel");
        idle(3);
        chk("mid-line swap o_front", int'(o_front), 1);

        // Reset mid-frame discards a pending back-bank write
        cyc1(1'b1, 3, 1'b1, 50, 1'b0, 1'b0, 0, 0, 1'b0, "");
        reset = 1'b1;
        #2;
        chk("async reset o_front", int'(o_front), 0);
        chk("async reset outputs", int'({o_valid, o_wall, o_side, o_ceiling, o_floor}), 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mFront = 1'b0; mDirty = 1'b0; mFv = 1'b0;
        cyc1(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, "");
        chk("swap after reset ignored", int'(o_front), 0);
        runPhase(5);

        idle(4);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
